// File: rtl/loop_ctrl_fault_filter.sv
// Loop-control fault filter: four synchronized raw fault inputs,
// each debounced by a set/clear hysteresis FSM with event counting.
module loop_ctrl_fault_filter #(
   parameter int THRESH = 8,
   parameter int STICKY = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CELV,
   input  logic       CELG,
   input  logic       SUB,
   input  logic       en,
   input  logic       clr,
   input  logic [3:0] raw_f,
   output logic       f0,
   output logic       f1,
   output logic       f2,
   output logic       f3,
   output logic       any_f,
   output logic [7:0] evt_cnt
);

   typedef enum logic [1:0] {
      S_CLR,
      S_PSET,
      S_SET,
      S_PCLR
   } state_t;

   localparam logic [3:0] TH  = 4'(THRESH);
   localparam bit         STK = (STICKY != 0);
   localparam bit         PASS = (THRESH == 1);

   logic [3:0] r_s1;
   logic [3:0] r_s2;
   state_t     r_state [4];
   logic [3:0] r_cnt   [4];
   logic [3:0] r_flag;
   logic       r_any;
   logic [7:0] r_evt;

   state_t     w_nstate [4];
   logic [3:0] w_ncnt   [4];
   logic [3:0] w_nflag;
   logic [3:0] w_rise;
   logic [2:0] w_nrise;
   logic [8:0] w_sum;
   logic       w_unused_pwr;

   // Power/substrate pins are physical only; fold them into a sink.
   assign w_unused_pwr = CELV ^ CELG ^ SUB;

   // Two-flop synchronizer on every raw fault bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= raw_f;
         r_s2 <= r_s1;
      end
   end

   // Per-channel hysteresis next-state and counter logic.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_nstate[i] = r_state[i];
         w_ncnt[i]   = r_cnt[i];
         if (clr) begin
            w_nstate[i] = S_CLR;
            w_ncnt[i]   = '0;
         end else if (en) begin
            unique case (r_state[i])
               S_CLR: begin
                  if (r_s2[i]) begin
                     if (PASS) begin
                        w_nstate[i] = S_SET;
                        w_ncnt[i]   = '0;
                     end else begin
                        w_nstate[i] = S_PSET;
                        w_ncnt[i]   = 4'd1;
                     end
                  end
               end
               S_PSET: begin
                  if (!r_s2[i]) begin
                     w_nstate[i] = S_CLR;
                     w_ncnt[i]   = '0;
                  end else if ((r_cnt[i] + 4'd1) == TH) begin
                     w_nstate[i] = S_SET;
                     w_ncnt[i]   = '0;
                  end else begin
                     w_ncnt[i]   = r_cnt[i] + 4'd1;
                  end
               end
               S_SET: begin
                  if (!r_s2[i] && !STK) begin
                     if (PASS) begin
                        w_nstate[i] = S_CLR;
                        w_ncnt[i]   = '0;
                     end else begin
                        w_nstate[i] = S_PCLR;
                        w_ncnt[i]   = 4'd1;
                     end
                  end
               end
               S_PCLR: begin
                  if (r_s2[i]) begin
                     w_nstate[i] = S_SET;
                     w_ncnt[i]   = '0;
                  end else if ((r_cnt[i] + 4'd1) == TH) begin
                     w_nstate[i] = S_CLR;
                     w_ncnt[i]   = '0;
                  end else begin
                     w_ncnt[i]   = r_cnt[i] + 4'd1;
                  end
               end
               default: begin
                  w_nstate[i] = S_CLR;
                  w_ncnt[i]   = '0;
               end
            endcase
         end
      end
   end

   // Flag is high in SET/PCLR; a rise is a 0->1 flag transition.
   always_comb begin
      w_nrise = '0;
      for (int i = 0; i < 4; i++) begin
         w_nflag[i] = (w_nstate[i] == S_SET) || (w_nstate[i] == S_PCLR);
         w_rise[i]  = w_nflag[i] & ~r_flag[i];
         w_nrise    = w_nrise + {2'b00, w_rise[i]};
      end
      w_sum = {1'b0, r_evt} + {6'd0, w_nrise};
   end

   // Channel FSM state, counters and registered flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_state[i] <= S_CLR;
            r_cnt[i]   <= '0;
         end
         r_flag <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_state[i] <= w_nstate[i];
            r_cnt[i]   <= w_ncnt[i];
         end
         r_flag <= w_nflag;
      end
   end

   // Status OR lags the flags by one cycle; event count saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_any <= 1'b0;
         r_evt <= '0;
      end else if (clr) begin
         r_any <= 1'b0;
         r_evt <= '0;
      end else begin
         r_any <= |r_flag;
         r_evt <= w_sum[8] ? 8'hFF : w_sum[7:0];
      end
   end

   assign f0      = r_flag[0];
   assign f1      = r_flag[1];
   assign f2      = r_flag[2];
   assign f3      = r_flag[3];
   assign any_f   = r_any;
   assign evt_cnt = r_evt;

endmodule

// File: tb/tb_loop_ctrl_fault_filter.sv
// Bench for loop_ctrl_fault_filter: three parameterizations share stimulus,
// checked every cycle against a run-length model plus literal expectations.
module tb_loop_ctrl_fault_filter;

   logic       clk = 1'b0;
   logic       rst;
   logic       CELV;
   logic       CELG;
   logic       SUB;
   logic       en;
   logic       clr;
   logic [3:0] raw_f;

   logic [3:0] d_f   [3];
   logic       d_any [3];
   logic [7:0] d_evt [3];

   int checks   = 0;
   int failures = 0;
   bit chk_on   = 1'b0;

   logic [3:0] m_s1;
   logic [3:0] m_s2;
   int         m_run  [3][4];
   logic [3:0] m_flag [3];
   int         m_evt  [3];
   logic       m_any  [3];

   loop_ctrl_fault_filter #(.THRESH(8), .STICKY(0)) u_a (
      .clk(clk), .rst(rst), .CELV(CELV), .CELG(CELG), .SUB(SUB),
      .en(en), .clr(clr), .raw_f(raw_f),
      .f0(d_f[0][0]), .f1(d_f[0][1]), .f2(d_f[0][2]), .f3(d_f[0][3]),
      .any_f(d_any[0]), .evt_cnt(d_evt[0])
   );

   loop_ctrl_fault_filter #(.THRESH(8), .STICKY(1)) u_b (
      .clk(clk), .rst(rst), .CELV(CELV), .CELG(CELG), .SUB(SUB),
      .en(en), .clr(clr), .raw_f(raw_f),
      .f0(d_f[1][0]), .f1(d_f[1][1]), .f2(d_f[1][2]), .f3(d_f[1][3]),
      .any_f(d_any[1]), .evt_cnt(d_evt[1])
   );

   loop_ctrl_fault_filter #(.THRESH(1), .STICKY(0)) u_c (
      .clk(clk), .rst(rst), .CELV(CELV), .CELG(CELG), .SUB(SUB),
      .en(en), .clr(clr), .raw_f(raw_f),
      .f0(d_f[2][0]), .f1(d_f[2][1]), .f2(d_f[2][2]), .f3(d_f[2][3]),
      .any_f(d_any[2]), .evt_cnt(d_evt[2])
   );

   initial forever #5 clk = ~clk;

   function automatic int th_of(input int k);
      return (k == 2) ? 1 : 8;
   endfunction

   function automatic bit st_of(input int k);
      return (k == 1);
   endfunction

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cfg=%0d got=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0;
      m_s2 = '0;
      for (int k = 0; k < 3; k++) begin
         m_flag[k] = '0;
         m_evt[k]  = 0;
         m_any[k]  = 1'b0;
         for (int c = 0; c < 4; c++) m_run[k][c] = 0;
      end
   endtask

   // Flag toggles after THRESH consecutive enabled cycles of the synced
   // input disagreeing with it; sticky configs never clear on input.
   task automatic model_step();
      logic [3:0] d;
      if (rst) begin
         model_reset();
      end else begin
         d    = m_s2;
         m_s2 = m_s1;
         m_s1 = raw_f;
         for (int k = 0; k < 3; k++) begin
            if (clr) begin
               m_flag[k] = '0;
               m_evt[k]  = 0;
               m_any[k]  = 1'b0;
               for (int c = 0; c < 4; c++) m_run[k][c] = 0;
            end else begin
               m_any[k] = |m_flag[k];
               if (en) begin
                  for (int c = 0; c < 4; c++) begin
                     if (m_flag[k][c] && st_of(k)) begin
                        m_run[k][c] = 0;
                     end else if (d[c] != m_flag[k][c]) begin
                        m_run[k][c]++;
                        if (m_run[k][c] == th_of(k)) begin
                           m_run[k][c]  = 0;
                           m_flag[k][c] = ~m_flag[k][c];
                           if (m_flag[k][c] && m_evt[k] < 255) m_evt[k]++;
                        end
                     end else begin
                        m_run[k][c] = 0;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      {CELV, CELG, SUB} = 3'($urandom);
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
               chk("model_flags", k, 32'(d_f[k]), 32'(m_flag[k]));
               chk("model_any", k, 32'(d_any[k]), 32'(m_any[k]));
               chk("model_evt", k, 32'(d_evt[k]), 32'(m_evt[k]));
            end
         end
      end
   end

   initial begin
      rst   = 1'b1;
      en    = 1'b1;
      clr   = 1'b0;
      raw_f = 4'h0;
      CELV  = 1'b1;
      CELG  = 1'b0;
      SUB   = 1'b0;
      model_reset();
      cyc();
      chk_on = 1'b1;
      cycn(2);
      chk("rst_flags", 0, 32'(d_f[0]), 32'h0);
      chk("rst_any", 0, 32'(d_any[0]), 32'h0);
      chk("rst_evt", 0, 32'(d_evt[0]), 32'h0);
      rst = 1'b0;

      raw_f = 4'b0001;
      cycn(9);
      chk("f0_c9", 0, 32'(d_f[0][0]), 32'h0);
      cyc();
      chk("f0_c10", 0, 32'(d_f[0][0]), 32'h1);
      chk("any_c10", 0, 32'(d_any[0]), 32'h0);
      chk("evt_c10", 0, 32'(d_evt[0]), 32'h1);
      cyc();
      chk("any_c11", 0, 32'(d_any[0]), 32'h1);
      raw_f = 4'b0000;
      cycn(12);
      chk("f0_clear", 0, 32'(d_f[0][0]), 32'h0);
      chk("f0_sticky", 1, 32'(d_f[1][0]), 32'h1);

      raw_f = 4'b0010;
      cycn(7);
      raw_f = 4'b0000;
      cycn(12);
      chk("f1_p7", 0, 32'(d_f[0][1]), 32'h0);
      chk("evt_p7", 0, 32'(d_evt[0]), 32'h1);
      raw_f = 4'b0010;
      cycn(8);
      raw_f = 4'b0000;
      cycn(2);
      chk("f1_p8", 0, 32'(d_f[0][1]), 32'h1);
      chk("evt_p8", 0, 32'(d_evt[0]), 32'h2);
      cycn(12);
      chk("f1_p8_clr", 0, 32'(d_f[0][1]), 32'h0);

      raw_f = 4'b0100;
      cycn(10);
      chk("f2_set", 0, 32'(d_f[0][2]), 32'h1);
      raw_f = 4'b0000;
      cycn(5);
      raw_f = 4'b0100;
      cyc();
      raw_f = 4'b0000;
      cycn(2);
      chk("f2_glitch", 0, 32'(d_f[0][2]), 32'h1);
      cycn(7);
      chk("f2_c25", 0, 32'(d_f[0][2]), 32'h1);
      cyc();
      chk("f2_c26", 0, 32'(d_f[0][2]), 32'h0);

      raw_f = 4'b0001;
      cycn(6);
      en = 1'b0;
      cycn(5);
      en = 1'b1;
      cycn(3);
      chk("en_f0_c14", 0, 32'(d_f[0][0]), 32'h0);
      cyc();
      chk("en_f0_c15", 0, 32'(d_f[0][0]), 32'h1);
      raw_f = 4'b0000;
      cycn(12);

      raw_f = 4'b1000;
      cycn(10);
      chk("f3_set", 1, 32'(d_f[1][3]), 32'h1);
      raw_f = 4'b0000;
      cycn(20);
      chk("f3_hold", 1, 32'(d_f[1][3]), 32'h1);
      chk("f3_nonsticky", 0, 32'(d_f[0][3]), 32'h0);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_flags", 1, 32'(d_f[1]), 32'h0);
      chk("clr_evt_a", 0, 32'(d_evt[0]), 32'h0);
      chk("clr_evt_b", 1, 32'(d_evt[1]), 32'h0);
      cycn(3);

      raw_f = 4'b1111;
      cycn(9);
      chk("all_c9", 0, 32'(d_f[0]), 32'h0);
      cyc();
      chk("all_c10", 0, 32'(d_f[0]), 32'hF);
      chk("all_evt", 0, 32'(d_evt[0]), 32'h4);
      raw_f = 4'b0000;
      cycn(12);
      for (int e = 0; e < 63; e++) begin
         raw_f = 4'b1111;
         cycn(11);
         raw_f = 4'b0000;
         cycn(11);
      end
      chk("sat_a", 0, 32'(d_evt[0]), 32'hFF);
      chk("sat_c", 2, 32'(d_evt[2]), 32'hFF);

      raw_f = 4'b0010;
      cycn(12);
      chk("pre_rst_f1", 0, 32'(d_f[0][1]), 32'h1);
      raw_f = 4'b0011;
      cycn(7);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_flags", 0, 32'(d_f[0]), 32'h0);
      chk("arst_any", 0, 32'(d_any[0]), 32'h0);
      chk("arst_evt", 0, 32'(d_evt[0]), 32'h0);
      cycn(2);
      rst = 1'b0;
      cycn(9);
      chk("post_rst_c9", 0, 32'(d_f[0][0]), 32'h0);
      cyc();
      chk("post_rst_c10", 0, 32'(d_f[0][0]), 32'h1);
      cycn(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/loop_ctrl_fault_filter.md
LOOP_CTRL_FAULT_FILTER -- requirements
Module: loop_ctrl_fault_filter

Interface
Parameters:
REQ-001 The block SHALL have parameter THRESH, default 8, meaning consecutive qualifying cycles to set or clear a flag; legal range 1..15.
REQ-002 The block SHALL have parameter STICKY, default 0, meaning that when it is 1 a set flag clears only on clr or reset.

Ports (name, direction, width, meaning):
REQ-003 clk  input  1  single block clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 CELV  input  1  supply pin; carries no logic function.
REQ-006 CELG  input  1  ground pin; carries no logic function.
REQ-007 SUB  input  1  substrate pin; carries no logic function.
REQ-008 en  input  1  filter enable; when low, counters hold and flags hold.
REQ-009 clr  input  1  synchronous clear of all flags, counters and sticky state.
REQ-010 raw_f  input  4  asynchronous raw loop fault sources, one bit per channel.
REQ-011 f0, f1, f2, f3  output  1 each  filtered fault flags, registered; these drive i0..i3 of the downstream 4-input NOR cell.
REQ-012 any_f  output  1  registered OR of f0..f3, provided for status readback.
REQ-013 evt_cnt  output  8  saturating count of flag rising edges across all channels.

Function
REQ-014 Each raw_f bit SHALL pass through a 2-flop synchronizer before use; sync latency is 2 cycles.
REQ-015 Each channel SHALL implement FSM states CLR, PSET, SET and PCLR, each with its own 4-bit counter.
REQ-016 CLR: if the synced input is 1, go to PSET with cnt=1; otherwise stay.
REQ-017 PSET: if the input is 1 and cnt+1==THRESH, go to SET; if the input is 1 otherwise, increment cnt; if the input is 0, return to CLR with cnt=0.
REQ-018 SET: the flag is 1; if the input is 0 and STICKY=0, go to PCLR with cnt=1; otherwise stay.
REQ-019 PCLR: if the input is 0 and cnt+1==THRESH, go to CLR; if the input is 0 otherwise, increment cnt; if the input is 1, return to SET with cnt=0.
REQ-020 When THRESH=1, the block SHALL treat PSET and PCLR as pass-through: the transition SHALL complete on the first qualifying cycle.
REQ-021 The flag output SHALL be 1 exactly in states SET and PCLR, registered, and SHALL update on the clock edge of the FSM transition.
REQ-022 Total latency from a raw edge to the flag SHALL be 2 + THRESH cycles, with the input held stable.
REQ-023 any_f SHALL be registered one cycle after f0..f3 update.
REQ-024 evt_cnt SHALL increment by the number of channels entering SET in that cycle (0..4), and SHALL saturate at 255 without wrap.
REQ-025 When en=0, FSM state and counters SHALL freeze while the synchronizers keep running; resuming SHALL continue from the frozen state.
REQ-026 clr SHALL have priority over en and over input activity; the cycle after clr, all FSMs SHALL be in CLR, cnt=0, flags=0 and evt_cnt=0.
REQ-027 Simultaneous set qualification on several channels SHALL be handled independently with no arbitration.
REQ-028 CELV, CELG and SUB SHALL NOT influence any logic.

Reset
REQ-029 Asserting rst SHALL immediately force synchronizers to 0, all FSMs to CLR, counters to 0, f0..f3=0, any_f=0 and evt_cnt=0, without waiting for a clock edge.
REQ-030 Deassertion SHALL be synchronized externally; the block SHALL resume from the reset state on the first clock after release.
REQ-031 rst asserted mid-PSET or mid-PCLR SHALL discard partial counts; no flag edge SHALL be produced afterwards from pre-reset history.

Verification
REQ-032 THRESH=8, raw_f[0] held high from cycle 0 -> f0 rises at cycle 10, any_f at cycle 11, evt_cnt=1.
REQ-033 raw_f[1] high for 7 cycles then low -> f1 stays 0 and evt_cnt unchanged; same with an 8-cycle pulse -> f1 rises.
REQ-034 f2 set, then raw_f[2] low for 5 cycles, high for 1, then low for 8 -> f2 stays 1 through the glitch and clears 8 cycles after the final falling edge reaches the sync output.
REQ-035 STICKY=1, f3 set, then raw_f[3] low for 20 cycles -> f3 remains 1; pulse clr -> f3=0 next cycle.
REQ-036 All four raw bits rise together -> f0..f3 rise on the same cycle and evt_cnt=4; 64 such events -> evt_cnt saturates at 255.
REQ-037 rst pulsed asynchronously while channel 0 is in PSET with cnt=5 -> outputs go to 0 immediately, and f0 needs a full 2+THRESH cycles after release.
